// File: rtl/spislave.sv
// rtl/spislave.sv - SPI responder with resynchronised pins, TX holding buffer and RX strobe; optional SPISLAVE_LSBFIRST_EN
module spislave (
    input  logic       clkin,
    input  logic       rst_n,
    input  logic       cpol,
    input  logic       cpha,
    input  logic       cspol,
`ifdef SPISLAVE_LSBFIRST_EN
    input  logic       lsbfirst,
`endif
    input  logic       sclk,
    input  logic       mosi,
    input  logic       cs,
    output logic       miso,
    output logic       misoen,
    input  logic [7:0] data_i,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic [7:0] data_o,
    output logic       rx_valid,
    output logic       active
);

    typedef enum logic {IDLE, SELECTED} state_e;

    logic       lsb;
`ifdef SPISLAVE_LSBFIRST_EN
    assign lsb = lsbfirst;
`else
    assign lsb = 1'b0;
`endif

    // [0] first sync stage, [1] second stage, [2] delayed copy for edge detect
    logic [2:0] sclk_sync_q;
    logic [1:0] mosi_sync_q;
    logic [1:0] cs_sync_q;

    state_e     state_q, state_d;
    logic       armed_q, armed_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_sh_q, rx_sh_d;
    logic [7:0] tx_sh_q, tx_sh_d;
    logic       miso_q, miso_d;
    logic [7:0] data_q, data_d;
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;

    logic       cs_act, sclk_rise, sclk_fall, lead, trail, sample, shift;
    logic       do_load;
    logic [7:0] load_src, rx_next;

    // Resynchronise the asynchronous SPI pins into the clkin domain
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= 3'b000;
            mosi_sync_q <= 2'b00;
            cs_sync_q   <= 2'b00;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], sclk};
            mosi_sync_q <= {mosi_sync_q[0], mosi};
            cs_sync_q   <= {cs_sync_q[0], cs};
        end
    end

    // Edge classification relative to the configured clock polarity/phase
    always_comb begin
        cs_act    = cs_sync_q[1] ^ cspol;
        sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
        sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
        lead      = cpol ? sclk_fall : sclk_rise;
        trail     = cpol ? sclk_rise : sclk_fall;
        sample    = cpha ? trail : lead;
        shift     = cpha ? lead : trail;
        load_src  = hold_full_q ? hold_q : 8'hFF;
    end

    // Transfer FSM: bit counting, shifters, holding buffer and RX delivery
    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q;
        bit_cnt_d   = bit_cnt_q;
        rx_sh_d     = rx_sh_q;
        tx_sh_d     = tx_sh_q;
        miso_d      = miso_q;
        data_d      = data_q;
        rx_valid_d  = 1'b0;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        do_load     = 1'b0;
        rx_next     = lsb ? {mosi_sync_q[1], rx_sh_q[7:1]} : {rx_sh_q[6:0], mosi_sync_q[1]};

        // After reset CS must be seen inactive once before a new selection,
        // so an interrupted transfer is never picked up mid-byte.
        if (!cs_act) begin
            armed_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                bit_cnt_d = 3'd0;
                if (cs_act && armed_q) begin
                    state_d = SELECTED;
                    do_load = ~cpha;
                end
            end
            SELECTED: begin
                if (!cs_act) begin
                    state_d   = IDLE;
                    bit_cnt_d = 3'd0;
                    rx_sh_d   = 8'h00;
                    tx_sh_d   = 8'h00;
                    miso_d    = 1'b0;
                end else if (sample) begin
                    rx_sh_d   = rx_next;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        data_d     = rx_next;
                        rx_valid_d = 1'b1;
                    end
                end else if (shift) begin
                    // A shift edge at count 0 starts a new byte: reload instead of shifting
                    if (bit_cnt_q == 3'd0) begin
                        do_load = 1'b1;
                    end else begin
                        tx_sh_d = lsb ? (tx_sh_q >> 1) : (tx_sh_q << 1);
                        miso_d  = lsb ? tx_sh_q[1] : tx_sh_q[6];
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_load) begin
            tx_sh_d = load_src;
            miso_d  = lsb ? load_src[0] : load_src[7];
            if (hold_full_q) begin
                hold_full_d = 1'b0;
            end
        end

        // The buffer only accepts a write while empty; on an underrun load
        // the shifter takes 0xFF and the buffer still captures the write.
        if (tx_load && !hold_full_q) begin
            hold_d      = data_i;
            hold_full_d = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            armed_q     <= 1'b0;
            bit_cnt_q   <= 3'd0;
            rx_sh_q     <= 8'h00;
            tx_sh_q     <= 8'h00;
            miso_q      <= 1'b0;
            data_q      <= 8'h00;
            rx_valid_q  <= 1'b0;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sh_q     <= rx_sh_d;
            tx_sh_q     <= tx_sh_d;
            miso_q      <= miso_d;
            data_q      <= data_d;
            rx_valid_q  <= rx_valid_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    assign miso     = miso_q;
    assign misoen   = (state_q == SELECTED);
    assign active   = (state_q == SELECTED);
    assign tx_ready = ~hold_full_q;
    assign data_o   = data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: doc/spislave.md
# spislave

SPI responder for the Bus Pirate Ultra: receives bytes from an external SPI master and returns a byte on MISO in the same transfer. It sits alongside the SPI master block in the same protocol family. All SPI pins are sampled and resynchronised into the `clkin` domain, so the block runs on one system clock. A one-byte transmit holding buffer and a received-byte strobe connect it to the host logic.

## Interface
No parameters.
- `clkin`  in  1  system clock; every register uses its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `cpol`  in  1  SCLK idle level.
- `cpha`  in  1  0 = sample on leading edge, 1 = sample on trailing edge.
- `cspol`  in  1  CS inactive level; the active level is `~cspol`.
- `sclk`  in  1  SPI clock from the master (asynchronous).
- `mosi`  in  1  master out, slave in (asynchronous).
- `cs`  in  1  chip select (asynchronous).
- `miso`  out  1  master in, slave out.
- `misoen`  out  1  MISO pad output enable; high only while selected.
- `data_i`  in  8  byte to transmit.
- `tx_load`  in  1  writes `data_i` into the holding buffer.
- `tx_ready`  out  1  holding buffer is empty.
- `data_o`  out  8  last complete received byte; held until the next one.
- `rx_valid`  out  1  one-cycle pulse when `data_o` updates.
- `active`  out  1  synchronised CS is active.

## Operation
- Reset values:
  - `miso`=0, `misoen`=0, `data_o`=0x00, `rx_valid`=0, `tx_ready`=1, `active`=0.
  - Bit counter = 0, shifters = 0x00, holding buffer empty.
- Synchronisers: `sclk`, `mosi` and `cs` each pass through a 2-FF synchroniser. Edge detection compares stage 2 with a third delayed copy.
  - Leading edge = SCLK leaves `cpol`.
  - Trailing edge = SCLK returns to `cpol`.
  - SCLK edges are ignored while CS is inactive.
- States:
  - IDLE: CS inactive. `misoen`=0, bit counter held at 0.
  - SELECTED: CS active. Bit counter runs 0..7 and wraps to 0 after each byte.
- Sample edge (leading if `cpha`=0, trailing if `cpha`=1):
  - Shift the synchronised MOSI into the RX shifter, MSB first.
  - On the 8th sample, copy the full byte to `data_o` and pulse `rx_valid` for one cycle.
- Shift edge (the other edge): present the next TX bit on `miso`.
- Shifter loading, `cpha`=0:
  - TX shifter loads on CS assertion and again on each 8th trailing edge.
  - Bit 7 appears on `miso` in the same cycle as the load.
- Shifter loading, `cpha`=1: TX shifter loads on the first leading edge of each byte, and bit 7 is driven on that edge.
- Load source:
  - Holding buffer full: load from the buffer; it empties and `tx_ready` rises the next cycle.
  - Buffer empty (underrun): load 0xFF.
- `tx_load` rules:
  - With `tx_ready`=1: captures `data_i`, and `tx_ready`=0 from the next cycle.
  - With `tx_ready`=0: ignored.
  - Coinciding with a shifter load while the buffer is empty: shifter gets 0xFF, buffer captures `data_i`.
- CS deasserted mid-byte:
  - Go to IDLE and zero the bit counter.
  - Discard the partial RX byte (no `rx_valid`) and the TX shifter contents.
  - A byte still in the holding buffer is kept.
- CS deasserted exactly after the 8th sample edge: the byte is still delivered.
- `cpol`, `cpha` and `cspol` must be stable while `active`=1. A change during a transfer gives an unspecified result for that byte only.

## Timing
- Maximum SCLK is `clkin`/8, with each SCLK phase at least 4 `clkin` cycles.
- `rx_valid` pulses 3 `clkin` cycles after the 8th sampling edge at the pin.
- `miso` changes 3 `clkin` cycles after the shift edge or CS assertion at the pin.
- `active` and `misoen` follow the CS pin with 3 cycles of latency.
- `tx_ready` rises exactly 1 cycle after a buffer-to-shifter load.
- Asynchronous `rst_n` forces all reset values immediately, including mid-byte. Operation resumes on the first `clkin` edge after release. A transfer that was in progress is not recovered until CS toggles.

## Configuration
- `SPISLAVE_LSBFIRST_EN` defined:
  - Adds input port `lsbfirst` (1 bit, after `cspol`).
  - When `lsbfirst`=1, both shifters run LSB first.
  - `lsbfirst` must be stable while `active`=1.
- Undefined: no `lsbfirst` port; MSB first always.

## Test plan
- Mode 0 (`cpol`=0, `cpha`=0, `cspol`=1), SCLK = `clkin`/8: load 0xA5, master sends 0x3C -> `data_o`=0x3C with a single `rx_valid` pulse; master receives 0xA5; `tx_ready` high again after the load.
- Mode 3 (`cpol`=1, `cpha`=1): two back-to-back bytes 0x81, 0x7E with 0x55 then 0xAA preloaded, the second written when `tx_ready` rises -> two `rx_valid` pulses carrying 0x81, 0x7E; MISO returns 0x55, 0xAA.
- Underrun: no `tx_load`, master sends 0x00 -> master receives 0xFF; `data_o`=0x00.
- CS deasserted after 5 bits, then a full byte 0xC3 -> only one `rx_valid`, with `data_o`=0xC3; preloaded 0x12 is sent in the full byte.
- `rst_n` pulsed low mid-byte -> all outputs at reset values within the same cycle; the next full transfer after CS toggles works normally.
- With `SPISLAVE_LSBFIRST_EN` and `lsbfirst`=1, master sends 0x01 LSB first with 0x80 preloaded -> `data_o`=0x01; MISO bit order is 0,0,0,0,0,0,0,1.
